wb_stage_p: RTL

- Parametrised, registered writeback stage; successor to the single-cycle combinational writeback mux.
- Holds the MEM/WB pipeline register and selects the writeback source from four options: ALU, memory, PC+4, immediate.
- Sign/zero-extends and aligns sub-word load data, suppresses illegal or x0 writes, and drives register-file write port plus forwarding outputs.
- Keeps a retired-instruction counter for debug/perf.

---
 rtl/wb_pkg.sv | 31 +++
 rtl/wb_load_ext.sv | 41 ++++
 rtl/wb_stage_p.sv | 112 +++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared codes and default widths for the registered writeback stage.
package wb_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned REG_AW_DEF = 5;
  localparam int unsigned RET_W_DEF  = 32;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;
  localparam logic [1:0] WB_SEL_IMM = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // A halfword needs an even offset and a word needs offset zero.
  function automatic logic load_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (funct3)
      F3_LH, F3_LHU: mis = addr_lo[0];
      F3_LW:         mis = (addr_lo != 2'b00);
      default:       mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/wb_load_ext.sv
// Sub-word load lane selection, sign/zero extension and misalignment detection.
module wb_load_ext
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] ext_data,
  output logic              misalign
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = mem_data[7:0];
    case (addr_lo)
      2'd1:    byte_lane = mem_data[15:8];
      2'd2:    byte_lane = mem_data[23:16];
      2'd3:    byte_lane = mem_data[31:24];
      default: byte_lane = mem_data[7:0];
    endcase
    half_lane = addr_lo[1] ? mem_data[31:16] : mem_data[15:0];
  end

  // Unknown load sizes and LW fall through with the raw word.
  always_comb begin
    ext_data = mem_data;
    case (funct3)
      F3_LB:   ext_data = {{(DATA_W-8){byte_lane[7]}}, byte_lane};
      F3_LBU:  ext_data = {{(DATA_W-8){1'b0}}, byte_lane};
      F3_LH:   ext_data = {{(DATA_W-16){half_lane[15]}}, half_lane};
      F3_LHU:  ext_data = {{(DATA_W-16){1'b0}}, half_lane};
      default: ext_data = mem_data;
    endcase
    misalign = load_misaligned(funct3, addr_lo);
  end

endmodule

// File: rtl/wb_stage_p.sv
// Registered MEM/WB stage: source mux, load extension, x0/misalign write
// suppression and a retired-instruction counter.
module wb_stage_p
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned RET_W  = RET_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic              reg_write_in,
  input  logic [REG_AW-1:0] rd_in,
  input  logic [1:0]        wb_sel,
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] alu_data,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] pc_plus4,
  input  logic [DATA_W-1:0] imm_data,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_misalign,
  output logic [RET_W-1:0]  retired
);

  logic              valid_q, valid_d;
  logic              we_q, we_d;
  logic              mis_q, mis_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [RET_W-1:0]  ret_q, ret_d;

  logic [DATA_W-1:0] ld_data;
  logic              ld_mis;
  logic              cap_mis;
  logic [DATA_W-1:0] src_data;

  wb_load_ext #(.DATA_W(DATA_W)) u_load_ext (
    .funct3   (funct3),
    .addr_lo  (addr_lo),
    .mem_data (mem_data),
    .ext_data (ld_data),
    .misalign (ld_mis)
  );

  always_comb begin
    src_data = alu_data;
    case (wb_sel)
      WB_SEL_MEM: src_data = ld_data;
      WB_SEL_PC4: src_data = pc_plus4;
      WB_SEL_IMM: src_data = imm_data;
      default:    src_data = alu_data;
    endcase
    cap_mis = (wb_sel == WB_SEL_MEM) & ld_mis;
  end

  // Flush beats stall; the counter tracks the instruction leaving WB.
  always_comb begin
    valid_d = valid_q;
    we_d    = we_q;
    mis_d   = mis_q;
    rd_d    = rd_q;
    data_d  = data_q;
    ret_d   = ret_q;
    if (valid_q && !stall) begin
      ret_d = ret_q + RET_W'(1);
    end
    if (flush) begin
      valid_d = 1'b0;
      we_d    = 1'b0;
      mis_d   = 1'b0;
    end else if (!stall) begin
      valid_d = in_valid;
      we_d    = in_valid & reg_write_in & (rd_in != '0) & ~cap_mis;
      mis_d   = in_valid & cap_mis;
      rd_d    = rd_in;
      data_d  = src_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
      ret_q   <= '0;
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      mis_q   <= mis_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      ret_q   <= ret_d;
    end
  end

  assign wb_valid    = valid_q;
  assign wb_we       = we_q;
  assign wb_rd       = rd_q;
  assign wb_data     = data_q;
  assign wb_misalign = mis_q;
  assign retired     = ret_q;

endmodule
